button_event_ctrl: RTL and testbench
====================================

Name: button_event_ctrl

Overview:
Avalon-MM slave controller for the board push-button inputs. It synchronises and debounces each button, latches selected edges into a capture register, and raises a maskable interrupt. It replaces the raw PIO input path on the QSYS fabric, so software sees clean levels and per-button events instead of sampling bouncing pins.

Parameters:
WIDTH, 4, number of button inputs (1..32)
DB_W, 20, width of the debounce period counter and register
DEFAULT_PERIOD, 20'd50000, debounce period in clk cycles after reset (1 ms at 50 MHz)
IDLE_LEVEL, 4'hF, reset and idle level of the inputs; buttons are active-low
EDGE_SEL, 0, edge captured: 0 = falling (press), 1 = rising (release), 2 = both

Ports:
clk  input  1  system clock; all logic runs in this single domain
reset_n  input  1  asynchronous, active-low reset
address  input  2  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe, qualified by chipselect
writedata  input  32  write data
readdata  output  32  registered read data
in_port  input  WIDTH  raw asynchronous button pins
irq  output  1  level interrupt, registered

Behaviour:
- Reset values: readdata=0, irq=0, irq mask=0, period=DEFAULT_PERIOD, edge capture=0. Synchroniser flops and debounced state reset to IDLE_LEVEL, so no edge is produced on reset release.
- Sync: two-flop synchroniser per bit. Debounce sees the input 2 cycles after the pin changes.
- Debounce FSM (per bit, states STABLE and CHECK; cnt is DB_W bits):
  - STABLE: if sync != stable, go to CHECK with cnt=0.
  - CHECK: if sync == stable, return to STABLE (bounce rejected). Else cnt++. When cnt >= period, set stable=sync, assert a 1-cycle change pulse, and go to STABLE.
  - period=0 means the new value commits on the first CHECK cycle.
  - A period write takes effect immediately. If cnt already >= the new period, commit on the next cycle.
  - cnt saturates and never wraps.
- Edge capture: bit i is set when the change pulse of bit i matches EDGE_SEL, using the new stable value (0 = falling, 1 = rising). A bit stays set until cleared.
- Register map (reads are zero-extended; unused bits read 0):
  - 0: RO debounced levels. Writes are ignored.
  - 1: RW irq mask [WIDTH-1:0].
  - 2: RW debounce period [DB_W-1:0].
  - 3: edge capture. A write clears every bit where writedata is 1 (W1C).
- A set event and a W1C clear on the same bit in the same cycle: set wins, and the bit stays 1.
- Read latency: readdata is registered every cycle from the address, with no read strobe, so it is valid 1 cycle after address is presented. A read of reg 3 in the cycle a set occurs returns the old value.
- irq is registered: irq <= |(edge_capture & mask). It asserts 1 cycle after the capture bit sets and deasserts 1 cycle after the clear or mask.
- A reset asserted mid-debounce aborts every FSM to STABLE=IDLE_LEVEL. No pulse is produced.

Optional Feature:
BUTTON_EVENT_CTRL_IRQ_EN
- Defined: mask register and irq behave as described above.
- Undefined: mask register is absent (reads 0, writes ignored) and irq is tied to 0. Edge capture still works for polling.

Decomposition:
- Package button_event_ctrl_pkg holds:
  - register address constants: ADDR_DATA=0, ADDR_MASK=1, ADDR_PERIOD=2, ADDR_EDGE=3
  - EDGE_SEL encodings: EDGE_FALL, EDGE_RISE, EDGE_ANY
  - the debounce FSM state enum
- One sub-module, btn_debounce: synchroniser, FSM and counter for a single bit. It outputs the stable level and the change pulse, and is instantiated WIDTH times via generate.
- The top level holds registers, edge capture and irq.

Test Plan:
- Reset check: release reset with in_port=4'hF, hold 100 cycles -> readdata=0, irq=0, reg3 reads 0, reg2 reads 50000.
- Clean press: set period=10, drive in_port[0]=0 -> reg0 bit0 goes 0 at cycle 2+11 from the pin change; reg3=32'h1; irq rises 1 cycle later only if mask=1.
- Bounce rejection: period=10, toggle in_port[1] low for 5 cycles then high, repeated 4 times -> reg0 stays 4'hF, reg3=0, no irq.
- W1C race: hold the clear write to reg3 (writedata=1) on the exact cycle bit0's press pulse fires -> reg3 bit0 remains 1; a second write clears it to 0 and irq drops 1 cycle later.
- Period change mid-count: period=100, press in_port[2], write period=5 at cnt=20 -> commit on the next cycle; reg3 bit2=1.
- Reset mid-operation: assert reset_n=0 during CHECK of bit3 -> after release reg0=4'hF, reg3=0, irq=0; with the pin still low, the FSM restarts and captures the press after the period.

Source files
------------

// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the push-button event controller: register map,
// edge-select encodings and the per-bit debounce state.
package button_event_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_EDGE   = 2'd3;

    typedef enum logic [1:0] {
        EDGE_FALL = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_sel_e;

    typedef enum logic {
        DB_STABLE = 1'b0,
        DB_CHECK  = 1'b1
    } db_state_e;

    // True when a committed level of new_level is an edge the capture register wants.
    function automatic logic edge_match(edge_sel_e sel, logic new_level);
        case (sel)
            EDGE_FALL: return ~new_level;
            EDGE_RISE: return new_level;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit two-flop synchroniser plus STABLE/CHECK debounce FSM with a
// saturating period counter; emits the debounced level and a 1-cycle change pulse.
module btn_debounce
    import button_event_ctrl_pkg::*;
#(
    parameter int unsigned DB_W       = 20,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pin_i,
    input  logic [DB_W-1:0] period_i,
    output logic            level_o,
    output logic            change_o
);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    db_state_e       state_q, state_d;
    logic [DB_W-1:0] cnt_q, cnt_d, cnt_inc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= IDLE_LEVEL;
            sync2_q  <= IDLE_LEVEL;
            stable_q <= IDLE_LEVEL;
            state_q  <= DB_STABLE;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + DB_W'(1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        change_o = 1'b0;
        case (state_q)
            DB_STABLE: begin
                if (sync2_q != stable_q) begin
                    state_d = DB_CHECK;
                    cnt_d   = '0;
                end
            end
            DB_CHECK: begin
                if (sync2_q == stable_q) begin
                    state_d = DB_STABLE;
                end else if (cnt_inc >= period_i) begin
                    // Compared against the live period so a shortened period commits at once.
                    stable_d = sync2_q;
                    change_o = 1'b1;
                    state_d  = DB_STABLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = DB_STABLE;
        endcase
    end

    assign level_o = stable_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Avalon-MM push-button controller: per-bit debounce, W1C edge capture and a
// registered interrupt. Define BUTTON_EVENT_CTRL_IRQ_EN to build the mask register and irq.
module button_event_ctrl
    import button_event_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH          = 4,
    parameter int unsigned      DB_W           = 20,
    parameter logic [DB_W-1:0]  DEFAULT_PERIOD = DB_W'(50000),
    parameter logic [WIDTH-1:0] IDLE_LEVEL     = {WIDTH{1'b1}},
    parameter edge_sel_e        EDGE_SEL       = EDGE_FALL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] level, change, set_vec, clr_vec;
    logic [WIDTH-1:0] cap_q, cap_d, mask_q;
    logic [DB_W-1:0]  period_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        btn_debounce #(
            .DB_W       (DB_W),
            .IDLE_LEVEL (IDLE_LEVEL[i])
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin_i    (in_port[i]),
            .period_i (period_q),
            .level_o  (level[i]),
            .change_o (change[i])
        );
        // A pulse always flips the level, so the new value is the inverse of the current one.
        assign set_vec[i] = change[i] & edge_match(EDGE_SEL, ~level[i]);
    end

    assign clr_vec = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign cap_d   = (cap_q & ~clr_vec) | set_vec;

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA:   rdata_d = 32'(level);
            ADDR_MASK:   rdata_d = 32'(mask_q);
            ADDR_PERIOD: rdata_d = 32'(period_q);
            default:     rdata_d = 32'(cap_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q    <= '0;
            period_q <= DEFAULT_PERIOD;
            rdata_q  <= '0;
        end else begin
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            if (wr_en && address == ADDR_PERIOD) begin
                period_q <= writedata[DB_W-1:0];
            end
        end
    end

    assign readdata = rdata_q;

`ifdef BUTTON_EVENT_CTRL_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            irq_q <= |(cap_q & mask_q);
            if (wr_en && address == ADDR_MASK) begin
                mask_q <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = irq_q;
`else
    assign mask_q = '0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench: directed scenarios plus random pin/bus traffic, all
// compared every cycle against a run-length reference model of the controller.
module tb_button_event_ctrl;
    import button_event_ctrl_pkg::*;

    localparam int        WIDTH   = 4;
    localparam int        DB_W    = 20;
    localparam edge_sel_e TB_EDGE = EDGE_FALL;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .WIDTH          (WIDTH),
        .DB_W           (DB_W),
        .DEFAULT_PERIOD (20'd50000),
        .IDLE_LEVEL     (4'hF),
        .EDGE_SEL       (TB_EDGE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    // Reference model: pins seen two cycles late; a level commits once it has
    // disagreed with the stable level for (period + 1) consecutive edges (min 2).
    bit [WIDTH-1:0] m_s1, m_s2, m_stable, m_cap, m_mask;
    int             m_run [WIDTH];
    bit [31:0]      m_period;
    bit [31:0]      m_rd;
    bit             m_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit edge_hit(bit new_level);
        case (TB_EDGE)
            EDGE_FALL: return !new_level;
            EDGE_RISE: return new_level;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic bit commit_next(int i);
        return (m_s2[i] != m_stable[i]) && (m_run[i] + 1 >= 2) && (m_run[i] >= int'(m_period));
    endfunction

    task automatic model_reset();
        m_s1     = '1;
        m_s2     = '1;
        m_stable = '1;
        m_cap    = '0;
        m_mask   = '0;
        m_period = 32'd50000;
        m_rd     = '0;
        m_irq    = 1'b0;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        bit [31:0]      rd_n;
        bit             irq_n;
        bit             wr;
        bit [WIDTH-1:0] st_n, set, clr;
        wr = chipselect && !write_n;
        case (address)
            ADDR_DATA:   rd_n = 32'(m_stable);
            ADDR_MASK:   rd_n = 32'(m_mask);
            ADDR_PERIOD: rd_n = m_period;
            default:     rd_n = 32'(m_cap);
        endcase
`ifdef BUTTON_EVENT_CTRL_IRQ_EN
        irq_n = |(m_cap & m_mask);
`else
        irq_n = 1'b0;
`endif
        st_n = m_stable;
        set  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (m_s2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] >= 2 && (m_run[i] - 1) >= int'(m_period)) begin
                    st_n[i]  = m_s2[i];
                    m_run[i] = 0;
                    set[i]   = edge_hit(m_s2[i]);
                end
            end else begin
                m_run[i] = 0;
            end
        end
        clr   = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        m_cap = (m_cap & ~clr) | set;
`ifdef BUTTON_EVENT_CTRL_IRQ_EN
        if (wr && address == ADDR_MASK) m_mask = writedata[WIDTH-1:0];
`endif
        if (wr && address == ADDR_PERIOD) m_period = {12'b0, writedata[DB_W-1:0]};
        m_stable = st_n;
        m_s2     = m_s1;
        m_s1     = in_port;
        m_rd     = rd_n;
        m_irq    = irq_n;
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("readdata", readdata, m_rd);
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_readdata", readdata, m_rd);
        check("rst_irq", 32'(irq), 32'(m_irq));
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("rst_readdata", readdata, m_rd);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        address    = ADDR_EDGE;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '1;
        apply_reset(3);

        // Idle after reset: capture stays clear, period reads its default.
        steps(50);
        address = ADDR_PERIOD;
        steps(50);

        // Clean press of bit 0 with a short period.
        bus_write(ADDR_PERIOD, 32'd10);
        bus_write(ADDR_MASK, 32'hF);
        address    = ADDR_DATA;
        in_port[0] = 1'b0;
        steps(18);
        address = ADDR_EDGE;
        steps(4);

        // Release bit 0, clear, then land a W1C exactly on the next press pulse.
        in_port[0] = 1'b1;
        steps(16);
        bus_write(ADDR_EDGE, 32'hF);
        steps(3);
        in_port[0] = 1'b0;
        for (int k = 0; k < 100 && !commit_next(0); k++) step();
        bus_write(ADDR_EDGE, 32'h1);
        address = ADDR_EDGE;
        steps(3);
        bus_write(ADDR_EDGE, 32'h1);
        steps(3);

        // Bounce on bit 1 shorter than the period is rejected.
        for (int r = 0; r < 4; r++) begin
            in_port[1] = 1'b0;
            address    = ADDR_DATA;
            steps(5);
            in_port[1] = 1'b1;
            address    = ADDR_EDGE;
            steps(5);
        end
        steps(5);

        // Period shortened mid-count on bit 2.
        bus_write(ADDR_PERIOD, 32'd100);
        in_port[2] = 1'b0;
        address    = ADDR_EDGE;
        for (int k = 0; k < 200 && m_run[2] != 21; k++) step();
        bus_write(ADDR_PERIOD, 32'd5);
        address = ADDR_EDGE;
        steps(5);
        in_port[2] = 1'b1;
        steps(12);
        bus_write(ADDR_EDGE, 32'hF);

        // Reset while bit 3 is counting; the held pin is captured again afterwards.
        in_port[3] = 1'b0;
        address    = ADDR_DATA;
        for (int k = 0; k < 50 && m_run[3] < 4; k++) step();
        apply_reset(3);
        address = ADDR_DATA;
        step();
        bus_write(ADDR_PERIOD, 32'd8);
        bus_write(ADDR_MASK, 32'hF);
        address = ADDR_EDGE;
        steps(16);
        address = ADDR_DATA;
        steps(3);

        // Randomised pin chatter and bus traffic, including period 0 and W1C races.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if ($urandom_range(0, 7) == 0) in_port[b] = ~in_port[b];
            end
            if ($urandom_range(0, 9) < 2) begin
                logic [1:0]  a;
                logic [31:0] d;
                a = 2'($urandom_range(0, 3));
                d = $urandom;
                if (a == ADDR_PERIOD) d = $urandom_range(0, 12);
                bus_write(a, d);
            end else begin
                address = 2'($urandom_range(0, 3));
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
